stream_accumulator_mc: RTL and testbench
========================================

Name: stream_accumulator_mc

Overview:
Multi-channel, parametrised signed fixed-point stream accumulator with AXI-Stream slave and master interfaces.
- Sums beats per channel, selected by s_axis_tid, until tlast, then emits one result beat per packet.
- Unlike the single-channel accumulator core, it has full backpressure (tready on both sides), interleaved channels, and a saturate/wrap mode with an overflow flag.
- Sits between datapath stages that produce partial products and the result collection logic.

Parameters:
DATA_W, 16, input sample width (signed two's complement)
ACC_W, 32, accumulator/result width (signed); must be >= DATA_W
NUM_CH, 4, number of independent channels (>= 1)
CH_W, $clog2(NUM_CH) (min 1), channel id width; derived, not overridden
SATURATE, 1, 1 = clamp on overflow; 0 = two's-complement wrap

Ports:
aclk  in  1  clock; all logic on rising edge
areset  in  1  synchronous, active-high reset
s_axis_tvalid  in  1  input beat valid
s_axis_tready  out  1  input beat accepted when tvalid && tready
s_axis_tdata  in  DATA_W  signed sample
s_axis_tid  in  CH_W  channel of this beat
s_axis_tlast  in  1  last beat of this channel's packet
m_axis_tvalid  out  1  result valid
m_axis_tready  in  1  downstream accepts result
m_axis_tdata  out  ACC_W  final packet sum
m_axis_tid  out  CH_W  channel of result
m_axis_tuser  out  1  overflow occurred anywhere in packet (sticky)

Behaviour:
- State per channel: acc[ch] (ACC_W), ovf[ch] (1). Single output register: m_valid, m_data, m_id, m_user.
- Reset (areset=1 at an edge): all acc=0, ovf=0; m_axis_tvalid=0, m_axis_tdata=0, m_axis_tid=0, m_axis_tuser=0.
  - A partial packet in flight is discarded. A pending result is dropped.
  - s_axis_tready=0 while areset is high.
- s_axis_tready = !areset && (!m_valid || m_axis_tready). This is a combinational path from m_axis_tready, and it is intended.
- On accept: sum = acc[ch] + sign-extended tdata, computed at ACC_W+1 bits.
  - Overflow is detected when the top two bits of sum differ.
  - SATURATE=1: on overflow, the result is clamped to +(2^(ACC_W-1)-1) or -2^(ACC_W-1). Later beats accumulate from the clamped value.
  - SATURATE=0: the result is the low ACC_W bits.
  - Either mode: novf = ovf[ch] | overflow.
- Accept with tlast=0: acc[ch] <= result; ovf[ch] <= novf. No output.
- Accept with tlast=1: m_data <= result, m_id <= ch, m_user <= novf, m_valid <= 1.
  - Same edge: acc[ch] <= 0 and ovf[ch] <= 0, ready for the next packet.
  - A single-beat packet yields result = sign-extended tdata.
- Latency: result is valid on the edge after the tlast beat is accepted (1 cycle).
- Output handshake:
  - m_valid clears on m_axis_tvalid && m_axis_tready unless a new tlast beat is accepted that same edge. In that case the register reloads and m_valid stays 1.
  - m_axis_tdata, m_axis_tid and m_axis_tuser are held stable while tvalid && !tready.
- Stall: while a result is pending and m_axis_tready=0, no input is accepted, on any channel. Channel state holds.
- Channels are fully independent. Beats from different channels may interleave arbitrarily. A tlast on one channel does not affect the others.
- tid >= NUM_CH (NUM_CH not a power of 2): the beat is accepted and discarded. No state change and no output, even with tlast.
- tvalid=0: no state change. tdata, tid and tlast are don't-care.

Test Plan:
- Ch0 beats 1, 2, 3(tlast), m_tready=1 -> one result tdata=6, tid=0, tuser=0, one cycle after the third beat; acc[0] then 0 (next packet 5(tlast) -> 5).
- Interleave ch1: 10, ch2: -4, ch1: 20(tlast), ch2: -6(tlast) -> results in order (30, tid1) then (-10 = 0xFFFFFFF6, tid2), tuser=0.
- ACC_W=16, SATURATE=1, ch0: 0x7000, 0x7000, -1(tlast) -> tdata=0x7FFE, tuser=1. Same stimulus with SATURATE=0 -> 0xDFFF, tuser=1. Next packet 1(tlast) -> 1, tuser=0.
- Backpressure: m_tready=0, ch0 packet 4(tlast), then ch1 beat 7 presented -> m_tvalid=1 with 4 held and s_tready=0 until m_tready=1. The ch1 beat is accepted on that same edge and m_tvalid falls next cycle.
- Reset mid-packet: ch3 beats 100, 200, areset pulse 1 cycle, then ch3 5(tlast) -> result 5, tid=3. All outputs read 0 the cycle after reset.
- Single-beat packet with tdata=0, tlast=1 on ch0 -> tdata=0, tuser=0. Back-to-back tlast every cycle on ch0 with m_tready=1 -> one result per cycle, no bubbles.

Source files
------------

// File: rtl/stream_accumulator_mc_if.sv
// AXI-Stream style beat bundle shared by the accumulator's input and result ports.
// The input side carries tlast, the result side carries tuser, so each modport exposes only its own fields.
interface stream_accumulator_mc_if #(
    parameter int DATA_W = 16,
    parameter int ID_W   = 2
) ();
    logic              tvalid;
    logic              tready;
    logic [DATA_W-1:0] tdata;
    logic [ID_W-1:0]   tid;
    logic              tlast;
    logic              tuser;

    modport master (output tvalid, output tdata, output tid, output tuser, input tready);
    modport slave  (input tvalid, input tdata, input tid, input tlast, output tready);
endinterface

// File: rtl/stream_accumulator_mc.sv
// Multi-channel signed stream accumulator that emits one sum per packet, with saturate or wrap on overflow.
// The result register is a single slot, so a stalled result blocks input on every channel.
module stream_accumulator_mc #(
    parameter int DATA_W   = 16,
    parameter int ACC_W    = 32,
    parameter int NUM_CH   = 4,
    parameter bit SATURATE = 1'b1,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                    aclk,
    input  logic                    areset,
    stream_accumulator_mc_if.slave  s_axis,
    stream_accumulator_mc_if.master m_axis
);

    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic [ACC_W-1:0]  acc [NUM_CH];
    logic [NUM_CH-1:0] ovf;

    logic              m_valid;
    logic [ACC_W-1:0]  m_data;
    logic [CH_W-1:0]   m_id;
    logic              m_user;

    logic              accept;
    logic              ch_ok;
    logic [ACC_W-1:0]  cur_acc;
    logic              cur_ovf;
    logic [ACC_W:0]    sum;
    logic              overflow;
    logic [ACC_W-1:0]  result;
    logic              novf;

    // Combinational from m_axis.tready so a draining result frees the slot on the same edge.
    assign s_axis.tready = !areset && (!m_valid || m_axis.tready);
    assign accept        = s_axis.tvalid && s_axis.tready;
    assign ch_ok         = int'(s_axis.tid) < NUM_CH;

    assign m_axis.tvalid = m_valid;
    assign m_axis.tdata  = m_data;
    assign m_axis.tid    = m_id;
    assign m_axis.tuser  = m_user;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        cur_acc = '0;
        cur_ovf = 1'b0;
        if (ch_ok) begin
            cur_acc = acc[s_axis.tid];
            cur_ovf = ovf[s_axis.tid];
        end

        sum      = {cur_acc[ACC_W-1], cur_acc}
                 + {{(ACC_W+1-DATA_W){s_axis.tdata[DATA_W-1]}}, s_axis.tdata};
        overflow = sum[ACC_W] ^ sum[ACC_W-1];
        novf     = cur_ovf | overflow;

        result = sum[ACC_W-1:0];
        if (SATURATE && overflow) begin
            result = sum[ACC_W] ? ACC_MIN : ACC_MAX;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            // NOTE: the per-channel array is reset because a packet in flight must be discarded.
            for (int ch = 0; ch < NUM_CH; ch++) begin
                acc[ch] <= '0;
            end
            ovf     <= '0;
            m_valid <= 1'b0;
            m_data  <= '0;
            m_id    <= '0;
            m_user  <= 1'b0;
        end else begin
            if (m_valid && m_axis.tready) begin
                m_valid <= 1'b0;
            end

            // Beats on an unpopulated channel id are consumed without effect.
            if (accept && ch_ok) begin
                if (s_axis.tlast) begin
                    m_valid              <= 1'b1;
                    m_data               <= result;
                    m_id                 <= s_axis.tid;
                    m_user               <= novf;
                    acc[s_axis.tid]      <= '0;
                    ovf[s_axis.tid]      <= 1'b0;
                end else begin
                    acc[s_axis.tid]      <= result;
                    ovf[s_axis.tid]      <= novf;
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_accumulator_mc.sv
// Scoreboard bench: a default 32-bit/4-channel accumulator plus 16-bit/3-channel saturate and wrap variants.
// Stimulus pushes expected results; per-DUT monitors pop and compare whenever a result handshakes.
module tb_stream_accumulator_mc;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  id;
        logic        user;
    } exp_t;

    logic aclk = 1'b0;
    logic areset;

    int checks = 0;
    int passes = 0;

    exp_t q0[$];
    exp_t q1[$];
    exp_t q2[$];
    exp_t e0, e1, e2;

    always #5 aclk = ~aclk;

    stream_accumulator_mc_if #(.DATA_W(16), .ID_W(2)) s0 ();
    stream_accumulator_mc_if #(.DATA_W(32), .ID_W(2)) m0 ();
    stream_accumulator_mc_if #(.DATA_W(16), .ID_W(2)) s1 ();
    stream_accumulator_mc_if #(.DATA_W(16), .ID_W(2)) m1 ();
    stream_accumulator_mc_if #(.DATA_W(16), .ID_W(2)) s2 ();
    stream_accumulator_mc_if #(.DATA_W(16), .ID_W(2)) m2 ();

    stream_accumulator_mc #(.DATA_W(16), .ACC_W(32), .NUM_CH(4), .SATURATE(1'b1)) dut_main (
        .aclk(aclk), .areset(areset), .s_axis(s0), .m_axis(m0));
    stream_accumulator_mc #(.DATA_W(16), .ACC_W(16), .NUM_CH(3), .SATURATE(1'b1)) dut_sat (
        .aclk(aclk), .areset(areset), .s_axis(s1), .m_axis(m1));
    stream_accumulator_mc #(.DATA_W(16), .ACC_W(16), .NUM_CH(3), .SATURATE(1'b0)) dut_wrap (
        .aclk(aclk), .areset(areset), .s_axis(s2), .m_axis(m2));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic push0(input logic [31:0] d, input logic [1:0] id, input logic user);
        exp_t e;
        e.data = d; e.id = id; e.user = user;
        q0.push_back(e);
    endtask

    task automatic push12(input logic [31:0] d_sat, input logic u_sat,
                          input logic [31:0] d_wrap, input logic u_wrap, input logic [1:0] id);
        exp_t e;
        e.data = d_sat; e.id = id; e.user = u_sat;
        q1.push_back(e);
        e.data = d_wrap; e.user = u_wrap;
        q2.push_back(e);
    endtask

    // Presents one beat on the main DUT and returns after the edge that accepts it.
    task automatic send0(input logic [1:0] id, input logic [15:0] d, input logic last, output int waited);
        s0.tvalid = 1'b1; s0.tid = id; s0.tdata = d; s0.tlast = last;
        waited = 0;
        @(negedge aclk);
        while (!s0.tready && waited < 50) begin
            @(negedge aclk);
            waited++;
        end
        check("s0_accept", 32'(s0.tready), 32'd1);
        @(posedge aclk);
        #1;
        s0.tvalid = 1'b0;
    endtask

    task automatic sendx(input logic [1:0] id, input logic [15:0] d, input logic last);
        int n;
        s1.tvalid = 1'b1; s1.tid = id; s1.tdata = d; s1.tlast = last;
        s2.tvalid = 1'b1; s2.tid = id; s2.tdata = d; s2.tlast = last;
        n = 0;
        @(negedge aclk);
        while (!(s1.tready && s2.tready) && n < 50) begin
            @(negedge aclk);
            n++;
        end
        check("s12_accept", 32'(s1.tready && s2.tready), 32'd1);
        @(posedge aclk);
        #1;
        s1.tvalid = 1'b0;
        s2.tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge aclk);
        #1;
    endtask

    always @(negedge aclk) begin
        if (m0.tvalid && m0.tready) begin
            if (q0.size() == 0) begin
                checks++;
                $display("FAIL m0_unexpected: got data=%h id=%0d, expected no result", m0.tdata, m0.tid);
            end else begin
                e0 = q0.pop_front();
                check("m0_data", m0.tdata, e0.data);
                check("m0_id", 32'(m0.tid), 32'(e0.id));
                check("m0_user", 32'(m0.tuser), 32'(e0.user));
            end
        end
    end

    always @(negedge aclk) begin
        if (m1.tvalid && m1.tready) begin
            if (q1.size() == 0) begin
                checks++;
                $display("FAIL m1_unexpected: got data=%h id=%0d, expected no result", m1.tdata, m1.tid);
            end else begin
                e1 = q1.pop_front();
                check("m1_sat_data", 32'(m1.tdata), e1.data);
                check("m1_sat_id", 32'(m1.tid), 32'(e1.id));
                check("m1_sat_user", 32'(m1.tuser), 32'(e1.user));
            end
        end
    end

    always @(negedge aclk) begin
        if (m2.tvalid && m2.tready) begin
            if (q2.size() == 0) begin
                checks++;
                $display("FAIL m2_unexpected: got data=%h id=%0d, expected no result", m2.tdata, m2.tid);
            end else begin
                e2 = q2.pop_front();
                check("m2_wrap_data", 32'(m2.tdata), e2.data);
                check("m2_wrap_id", 32'(m2.tid), 32'(e2.id));
                check("m2_wrap_user", 32'(m2.tuser), 32'(e2.user));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int w;
        areset = 1'b1;
        s0.tvalid = 1'b0; s0.tid = '0; s0.tdata = '0; s0.tlast = 1'b0;
        s1.tvalid = 1'b0; s1.tid = '0; s1.tdata = '0; s1.tlast = 1'b0;
        s2.tvalid = 1'b0; s2.tid = '0; s2.tdata = '0; s2.tlast = 1'b0;
        m0.tready = 1'b1; m1.tready = 1'b1; m2.tready = 1'b1;

        // Reset state
        repeat (2) @(posedge aclk);
        @(negedge aclk);
        check("rst_s_tready", 32'(s0.tready), 32'd0);
        check("rst_m_tvalid", 32'(m0.tvalid), 32'd0);
        check("rst_m_tdata", m0.tdata, 32'd0);
        check("rst_m_tuser", 32'(m0.tuser), 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        idle(1);

        // Basic packet 1,2,3 on ch0, one-cycle latency, then accumulator restarts at zero
        push0(32'd6, 2'd0, 1'b0);
        send0(2'd0, 16'd1, 1'b0, w);
        send0(2'd0, 16'd2, 1'b0, w);
        send0(2'd0, 16'd3, 1'b1, w);
        check("lat_valid", 32'(m0.tvalid), 32'd1);
        check("lat_data", m0.tdata, 32'd6);
        push0(32'd5, 2'd0, 1'b0);
        send0(2'd0, 16'd5, 1'b1, w);
        idle(2);
        check("drain_valid", 32'(m0.tvalid), 32'd0);

        // Interleaved channels 1 and 2
        send0(2'd1, 16'd10, 1'b0, w);
        send0(2'd2, -16'sd4, 1'b0, w);
        push0(32'd30, 2'd1, 1'b0);
        send0(2'd1, 16'd20, 1'b1, w);
        push0(32'hFFFF_FFF6, 2'd2, 1'b0);
        send0(2'd2, -16'sd6, 1'b1, w);
        idle(2);

        // Backpressure: result 4 held, ch1 beat 7 stalled until downstream is ready
        m0.tready = 1'b0;
        push0(32'd4, 2'd0, 1'b0);
        send0(2'd0, 16'd4, 1'b1, w);
        s0.tvalid = 1'b1; s0.tid = 2'd1; s0.tdata = 16'd7; s0.tlast = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge aclk);
            check("bp_s_tready", 32'(s0.tready), 32'd0);
            check("bp_m_tvalid", 32'(m0.tvalid), 32'd1);
            check("bp_m_tdata_held", m0.tdata, 32'd4);
        end
        @(posedge aclk); #1;
        m0.tready = 1'b1;
        @(negedge aclk);
        check("bp_release_s_tready", 32'(s0.tready), 32'd1);
        @(posedge aclk); #1;
        s0.tvalid = 1'b0;
        @(negedge aclk);
        check("bp_m_tvalid_fall", 32'(m0.tvalid), 32'd0);
        @(posedge aclk); #1;
        push0(32'd8, 2'd1, 1'b0);
        send0(2'd1, 16'd1, 1'b1, w);
        idle(2);

        // Reset mid-packet on ch3 discards the partial sum and clears held outputs
        send0(2'd3, 16'd100, 1'b0, w);
        send0(2'd3, 16'd200, 1'b0, w);
        areset = 1'b1;
        @(negedge aclk);
        check("rst2_s_tready", 32'(s0.tready), 32'd0);
        @(posedge aclk); #1;
        areset = 1'b0;
        @(negedge aclk);
        check("rst2_m_tvalid", 32'(m0.tvalid), 32'd0);
        check("rst2_m_tdata", m0.tdata, 32'd0);
        check("rst2_m_tid", 32'(m0.tid), 32'd0);
        check("rst2_m_tuser", 32'(m0.tuser), 32'd0);
        @(posedge aclk); #1;
        push0(32'd5, 2'd3, 1'b0);
        send0(2'd3, 16'd5, 1'b1, w);
        idle(2);

        // Single-beat zero packet, then back-to-back single-beat packets with no bubbles
        push0(32'd0, 2'd0, 1'b0);
        send0(2'd0, 16'd0, 1'b1, w);
        for (int i = 1; i <= 5; i++) begin
            push0(32'(i * 3), 2'd0, 1'b0);
            send0(2'd0, 16'(i * 3), 1'b1, w);
            check("b2b_no_wait", 32'(w), 32'd0);
        end
        idle(3);

        // 16-bit positive overflow: saturate clamps, wrap keeps low bits; flag sticky for the packet
        sendx(2'd0, 16'h7000, 1'b0);
        sendx(2'd0, 16'h7000, 1'b0);
        push12(32'h7FFE, 1'b1, 32'hDFFF, 1'b1, 2'd0);
        sendx(2'd0, 16'hFFFF, 1'b1);
        push12(32'h0001, 1'b0, 32'h0001, 1'b0, 2'd0);
        sendx(2'd0, 16'h0001, 1'b1);

        // Negative overflow on ch1
        sendx(2'd1, 16'h9000, 1'b0);
        push12(32'h8000, 1'b1, 32'h2000, 1'b1, 2'd1);
        sendx(2'd1, 16'h9000, 1'b1);

        // tid beyond NUM_CH=3 is swallowed without touching ch2
        sendx(2'd2, 16'd3, 1'b0);
        sendx(2'd3, 16'd100, 1'b1);
        push12(32'd7, 1'b0, 32'd7, 1'b0, 2'd2);
        sendx(2'd2, 16'd4, 1'b1);
        idle(4);

        check("q0_empty", 32'(q0.size()), 32'd0);
        check("q1_empty", 32'(q1.size()), 32'd0);
        check("q2_empty", 32'(q2.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
